// File: rtl/mt_cs1_multi.sv
// Per-drive MT CS1 register bank: function latch, GO/busy tracking, busy timeout,
// ILF/RMR/TMOE error flags and attention, with a zero-latency CS1 image of the selected drive.
module mt_cs1_multi #(
  parameter int              NDRV      = 8,
  parameter int              SELW      = 3,
  parameter logic [31:0]     LEGAL_FUN = 32'hFFFF_FFFF,
  parameter int              TMOW      = 16,
  parameter logic [TMOW-1:0] TMO       = 16'd50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [35:0]       mtDATAI,
  input  logic              mtWRCS1,
  input  logic [SELW-1:0]   mtSEL,
  input  logic [NDRV-1:0]   mtDONE,
  input  logic [NDRV-1:0]   mtCLR,
  input  logic [NDRV-1:0]   mtCLRATA,
  output logic [15:0]       mtCS1,
  output logic [NDRV-1:0]   mtGO,
  output logic [5*NDRV-1:0] mtFUN,
  output logic [NDRV-1:0]   mtILF,
  output logic [NDRV-1:0]   mtRMR,
  output logic [NDRV-1:0]   mtTMOE,
  output logic [NDRV-1:0]   mtATA
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state [NDRV];
  logic [TMOW-1:0]   cnt   [NDRV];
  logic [5*NDRV-1:0] fun;
  logic [NDRV-1:0]   ilf, rmr, tmoe, ata;
  logic [NDRV-1:0]   wr_hit, tmo_hit, go;
  logic [4:0]        wr_fun;
  logic              wr_go, wr_legal;
  logic              data_unused;

  assign wr_fun      = mtDATAI[5:1];
  assign wr_go       = mtDATAI[0];
  assign wr_legal    = LEGAL_FUN[wr_fun];
  assign data_unused = ^mtDATAI[35:6];

  always_comb begin
    wr_hit  = '0;
    tmo_hit = '0;
    go      = '0;
    for (int i = 0; i < NDRV; i++) begin
      wr_hit[i]  = mtWRCS1 && (mtSEL == SELW'(i));
      tmo_hit[i] = (TMO != '0) && (cnt[i] == TMO - 1'b1);
      go[i]      = (state[i] == BUSY);
    end
  end

  // Later assignments override earlier ones, so an error/attention set beats a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fun  <= '0;
      ilf  <= '0;
      rmr  <= '0;
      tmoe <= '0;
      ata  <= '0;
      for (int i = 0; i < NDRV; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NDRV; i++) begin
        if (mtCLR[i]) begin
          ilf[i]  <= 1'b0;
          rmr[i]  <= 1'b0;
          tmoe[i] <= 1'b0;
        end
        if (mtCLRATA[i]) ata[i] <= 1'b0;
        case (state[i])
          IDLE: begin
            if (wr_hit[i]) begin
              fun[5*i +: 5] <= wr_fun;
              if (wr_go && wr_legal) begin
                state[i] <= BUSY;
                cnt[i]   <= '0;
                ilf[i]   <= 1'b0;
                rmr[i]   <= 1'b0;
                tmoe[i]  <= 1'b0;
              end else if (wr_go) begin
                ilf[i] <= 1'b1;
                ata[i] <= 1'b1;
              end
            end
          end
          BUSY: begin
            if (wr_hit[i]) rmr[i] <= 1'b1;
            // Completion takes priority over a timeout landing on the same edge.
            if (mtDONE[i]) begin
              state[i] <= IDLE;
              ata[i]   <= 1'b1;
            end else if (tmo_hit[i]) begin
              state[i] <= IDLE;
              tmoe[i]  <= 1'b1;
              ata[i]   <= 1'b1;
            end else if (cnt[i] != '1) begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    mtCS1 = '0;
    for (int i = 0; i < NDRV; i++) begin
      if (mtSEL == SELW'(i)) mtCS1 = {4'b0, 1'b1, 5'b0, fun[5*i +: 5], go[i]};
    end
  end

  assign mtGO   = go;
  assign mtFUN  = fun;
  assign mtILF  = ilf;
  assign mtRMR  = rmr;
  assign mtTMOE = tmoe;
  assign mtATA  = ata;

endmodule

// File: tb/tb_mt_cs1_multi.sv
// Scoreboard bench for mt_cs1_multi: four drives, function 2 illegal, 10-clock busy timeout.
module tb_mt_cs1_multi;

  localparam int NDRV = 4;
  localparam int SELW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [35:0]       mtDATAI = '0;
  logic              mtWRCS1 = 1'b0;
  logic [SELW-1:0]   mtSEL = '0;
  logic [NDRV-1:0]   mtDONE = '0;
  logic [NDRV-1:0]   mtCLR = '0;
  logic [NDRV-1:0]   mtCLRATA = '0;
  logic [15:0]       mtCS1;
  logic [NDRV-1:0]   mtGO;
  logic [5*NDRV-1:0] mtFUN;
  logic [NDRV-1:0]   mtILF, mtRMR, mtTMOE, mtATA;

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] obs[$];
  int          checks = 0;
  int          passes = 0;

  mt_cs1_multi #(
    .NDRV(NDRV), .SELW(SELW), .LEGAL_FUN(32'hFFFF_FFFB), .TMOW(16), .TMO(16'd10)
  ) dut (
    .clk(clk), .rst(rst), .mtDATAI(mtDATAI), .mtWRCS1(mtWRCS1), .mtSEL(mtSEL),
    .mtDONE(mtDONE), .mtCLR(mtCLR), .mtCLRATA(mtCLRATA), .mtCS1(mtCS1), .mtGO(mtGO),
    .mtFUN(mtFUN), .mtILF(mtILF), .mtRMR(mtRMR), .mtTMOE(mtTMOE), .mtATA(mtATA)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected per-drive status word built from the bench's own view of the drive.
  function automatic logic [63:0] mk(logic [4:0] f, logic g, logic il, logic rm, logic tm, logic at);
    logic [15:0] cs1;
    cs1 = {4'b0, 1'b1, 5'b0, f, g};
    return {38'b0, cs1, g, il, rm, tm, at, f};
  endfunction

  function automatic logic [63:0] drv_status(int d);
    return {38'b0, mtCS1, mtGO[d], mtILF[d], mtRMR[d], mtTMOE[d], mtATA[d], mtFUN[5*d +: 5]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    mtWRCS1  = 1'b0;
    mtDONE   = '0;
    mtCLR    = '0;
    mtCLRATA = '0;
  endtask

  task automatic write_cs1(int d, logic [35:0] data);
    mtSEL   = SELW'(d);
    mtDATAI = data;
    mtWRCS1 = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    mtSEL = '0;
    sb.push_back('{"reset_state", mk(5'd0, 0, 0, 0, 0, 0)});
    tick();
    obs.push_back(drv_status(0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs.pop_front() !== e.val) $display("[TB] FAIL %s: status differs from required %h", e.name, e.val);
      else passes++;
    end
  endtask

  task automatic test_start_done();
    exp_t e;
    logic [63:0] o;
    write_cs1(2, 36'o71);
    sb.push_back('{"start_d2", mk(5'o34, 1, 0, 0, 0, 0)});
    tick();
    obs.push_back(drv_status(2));
    mtDONE[2] = 1'b1;
    sb.push_back('{"done_d2", mk(5'o34, 0, 0, 0, 0, 1)});
    tick();
    obs.push_back(drv_status(2));
    mtCLRATA[2] = 1'b1;
    sb.push_back('{"clrata_d2", mk(5'o34, 0, 0, 0, 0, 0)});
    tick();
    obs.push_back(drv_status(2));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      checks++;
      if (o !== e.val) $display("[TB] FAIL %s: got %h, want %h", e.name, o, e.val);
      else passes++;
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    logic [63:0] o;
    write_cs1(1, 36'd5);
    sb.push_back('{"illegal_d1", mk(5'd2, 0, 1, 0, 0, 1)});
    tick();
    obs.push_back(drv_status(1));
    mtCLR[1] = 1'b1;
    sb.push_back('{"clr_d1", mk(5'd2, 0, 0, 0, 0, 1)});
    tick();
    obs.push_back(drv_status(1));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      checks++;
      if (o !== e.val) $display("[TB] FAIL %s: got %h, want %h", e.name, o, e.val);
      else passes++;
    end
  endtask

  task automatic test_rmr();
    exp_t e;
    logic [63:0] o;
    write_cs1(0, 36'd7);
    sb.push_back('{"start_d0", mk(5'd3, 1, 0, 0, 0, 0)});
    tick();
    obs.push_back(drv_status(0));
    write_cs1(0, 36'o21);
    sb.push_back('{"rmr_d0", mk(5'd3, 1, 0, 1, 0, 0)});
    tick();
    obs.push_back(drv_status(0));
    mtDONE[0] = 1'b1;
    sb.push_back('{"done_d0", mk(5'd3, 0, 0, 1, 0, 1)});
    tick();
    obs.push_back(drv_status(0));
    write_cs1(0, 36'd7);
    sb.push_back('{"restart_d0", mk(5'd3, 1, 0, 0, 0, 1)});
    tick();
    obs.push_back(drv_status(0));
    write_cs1(0, 36'o21);
    mtDONE[0] = 1'b1;
    sb.push_back('{"rmr_with_done_d0", mk(5'd3, 0, 0, 1, 0, 1)});
    tick();
    obs.push_back(drv_status(0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      checks++;
      if (o !== e.val) $display("[TB] FAIL %s: got %h, want %h", e.name, o, e.val);
      else passes++;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    logic [63:0] o;
    int n;
    write_cs1(3, 36'd3);
    sb.push_back('{"busy_cycles_d3", 64'd10});
    tick();
    n = 0;
    while (mtGO[3] && n < 30) begin
      n++;
      tick();
    end
    obs.push_back(64'(n));
    sb.push_back('{"timeout_d3", mk(5'd1, 0, 0, 0, 1, 1)});
    obs.push_back(drv_status(3));
    mtCLRATA[3] = 1'b1;
    tick();
    write_cs1(3, 36'd3);
    tick();
    repeat (9) tick();
    mtDONE[3] = 1'b1;
    sb.push_back('{"done_beats_timeout_d3", mk(5'd1, 0, 0, 0, 0, 1)});
    tick();
    obs.push_back(drv_status(3));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      checks++;
      if (o !== e.val) $display("[TB] FAIL %s: got %h, want %h", e.name, o, e.val);
      else passes++;
    end
  endtask

  task automatic test_bad_select();
    exp_t e;
    logic [63:0] o;
    write_cs1(7, 36'd3);
    sb.push_back('{"sel7_cs1_go", 64'h0});
    tick();
    obs.push_back({44'b0, mtCS1, mtGO});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      checks++;
      if (o !== e.val) $display("[TB] FAIL %s: got %h, want %h", e.name, o, e.val);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [63:0] o;
    write_cs1(1, 36'd5);
    mtCLR[1]    = 1'b1;
    mtCLRATA[1] = 1'b1;
    sb.push_back('{"set_beats_clear_d1", mk(5'd2, 0, 1, 0, 0, 1)});
    tick();
    obs.push_back(drv_status(1));
    write_cs1(2, 36'o71);
    tick();
    mtDONE[2]   = 1'b1;
    mtCLRATA[2] = 1'b1;
    sb.push_back('{"ata_set_beats_clr_d2", mk(5'o34, 0, 0, 0, 0, 1)});
    tick();
    obs.push_back(drv_status(2));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      checks++;
      if (o !== e.val) $display("[TB] FAIL %s: got %h, want %h", e.name, o, e.val);
      else passes++;
    end
  endtask

  task automatic test_reset_midop();
    exp_t e;
    logic [63:0] o;
    write_cs1(0, 36'd7);
    tick();
    write_cs1(2, 36'o71);
    tick();
    mtSEL = '0;
    #2 rst = 1'b0;
    sb.push_back('{"async_reset_midop", {8'b0, 40'b0, 16'h0800}});
    #1;
    obs.push_back({8'b0, mtGO, mtILF, mtRMR, mtTMOE, mtATA, mtFUN, mtCS1});
    #2 rst = 1'b1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      checks++;
      if (o !== e.val) $display("[TB] FAIL %s: got %h, want %h", e.name, o, e.val);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_start_done();
    test_illegal();
    test_rmr();
    test_timeout();
    test_bad_select();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
